pipeline_stall_ctrl: RTL
========================

Name: pipeline_stall_ctrl

Overview:
Central stall controller for the five-stage pipeline. It merges stall requests from IF, ID, EX and MEM into the stall vector that drives every inter-stage pipeline register (PC/IFID/IDEX/EXMEM/MEMWB). Each register takes stall[i] as its current-stage stall and stall[i+1] as its next-stage stall. The block owns two pieces of sequencing: an EX multi-cycle occupancy counter (mult/div) and a MEM bus wait/timeout FSM.

Parameters:
STALL_WIDTH, 6, stall vector width; bit0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB
EX_CNT_WIDTH, 6, width of EX cycle count and counter
MEM_TIMEOUT, 64, MEM wait cycles before forced release (legal range 2..1023)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-low
if_stall_req  in  1  IF cannot deliver an instruction this cycle
id_stall_req  in  1  load-use hazard detected in ID
ex_op_start  in  1  1-cycle pulse: multi-cycle op entered EX
ex_op_cycles  in  EX_CNT_WIDTH  total EX occupancy N of the op
ex_flush  in  1  abort the in-flight EX op
mem_req  in  1  MEM stage has an access on the bus this cycle
mem_ack  in  1  bus completes the access this cycle
stall  out  STALL_WIDTH  stall vector to pipeline registers and PC
ex_op_done  out  1  1-cycle pulse: EX result valid this cycle
ex_busy  out  1  EX counter active (cnt != 0)
mem_busy  out  1  MEM FSM in WAIT
mem_timeout  out  1  1-cycle pulse: MEM wait aborted by timeout

Behaviour:
- Reset (rst=0 at clk edge): cnt=0, FSM=IDLE, timer=0. While rst=0, all outputs are forced to 0 combinationally.
- Stall vector: combinational, fixed priority. First match wins:
  - mem_stall -> 6'b011111
  - ex_stall -> 6'b001111
  - id_stall_req -> 6'b000111
  - if_stall_req -> 6'b000011
  - otherwise 6'b000000
  - WB (bit5) is never stalled.
- MEM FSM, states IDLE and WAIT:
  - IDLE, mem_req=1 and mem_ack=0: mem_stall=1; next state WAIT; timer<=1.
  - IDLE, mem_req=1 and mem_ack=1: no stall; stay IDLE.
  - WAIT, mem_ack=1: mem_stall=0 this same cycle; next state IDLE; timer<=0.
  - WAIT, mem_ack=0 and timer==MEM_TIMEOUT-1: mem_stall=0; mem_timeout=1 this cycle; next state IDLE.
  - WAIT, otherwise: mem_stall=1; timer<=timer+1.
  - mem_req is not sampled in WAIT.
  - mem_busy = (state==WAIT).
- EX counter:
  - ex_op_start with N>=2 and cnt==0: ex_stall=1 in the start cycle; cnt<=N-1.
  - cnt>1: ex_stall=1.
  - cnt==1: ex_stall=0 and ex_op_done=1.
  - Net effect: the op occupies EX for exactly N cycles, with N-1 of them stalled.
  - ex_op_start with N<=1: no stall; ex_op_done=1 combinationally in the start cycle; cnt unchanged.
  - ex_op_start while cnt!=0: ignored.
  - Counter update, evaluated in order:
    - cnt is decremented only when mem_stall=0 (MEM back-pressure freezes EX).
    - When cnt==1, ex_op_done asserts only if mem_stall=0; otherwise it holds until MEM releases.
    - ex_flush=1: cnt<=0 next cycle; no ex_op_done in that cycle. ex_flush has priority over ex_op_start and over the decrement.
  - ex_busy = (cnt!=0).
- Simultaneous requests: all internal state keeps updating per the rules above; only the priority encoder selects the output pattern.
- A stalled id/if request needs no memory in this block; requesters hold their request until released.

Test Plan:
- rst=0 for 2 cycles with all requests high -> stall=0, ex_busy=0, mem_busy=0 throughout; after rst=1 with only id_stall_req=1 -> stall=6'b000111.
- ex_op_start, ex_op_cycles=4, no other requests -> stall=6'b001111 for 3 cycles, then stall=0 with ex_op_done=1 in cycle 4; ex_busy high in cycles 2-4 only.
- mem_req=1 with mem_ack low for 3 cycles, then ack -> stall=6'b011111 for 3 cycles, 0 in ack cycle; mem_busy=1 in cycles 2-4.
- MEM_TIMEOUT=8, mem_req=1 with ack never asserted -> stall=6'b011111 for 7 cycles; mem_timeout=1 and stall=0 in cycle 8; FSM back to IDLE.
- EX op N=5 started, MEM wait of 2 cycles overlapping cnt=3 -> stall=6'b011111 for those 2 cycles, cnt frozen at 3; ex_op_done delayed by 2 cycles (EX occupancy 7 cycles).
- EX op N=6, ex_flush on 2nd cycle -> ex_busy=0 from 3rd cycle, no ex_op_done; ex_op_cycles=1 start -> ex_op_done=1 same cycle, stall=0.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// Central stall controller for the five-stage pipeline: merges IF/ID/EX/MEM
// stall sources into one priority-encoded stall vector, and sequences EX multi-cycle ops and MEM bus waits.
module pipeline_stall_ctrl #(
    parameter int STALL_WIDTH  = 6,
    parameter int EX_CNT_WIDTH = 6,
    parameter int MEM_TIMEOUT  = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_stall_req,
    input  logic                    id_stall_req,
    input  logic                    ex_op_start,
    input  logic [EX_CNT_WIDTH-1:0] ex_op_cycles,
    input  logic                    ex_flush,
    input  logic                    mem_req,
    input  logic                    mem_ack,
    output logic [STALL_WIDTH-1:0]  stall,
    output logic                    ex_op_done,
    output logic                    ex_busy,
    output logic                    mem_busy,
    output logic                    mem_timeout
);

    localparam int TIMER_WIDTH = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(MEM_TIMEOUT - 1);

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_t;

    mem_state_t               mem_state;
    logic [TIMER_WIDTH-1:0]   mem_timer;
    logic [EX_CNT_WIDTH-1:0]  ex_cnt;

    logic mem_stall;
    logic mem_expire;
    logic ex_stall;
    logic ex_start_ok;
    logic ex_multi;
    logic ex_done_raw;

    // MEM wait decode: release happens in the ack or expiry cycle itself.
    always_comb begin
        mem_stall  = 1'b0;
        mem_expire = 1'b0;
        if (mem_state == MEM_IDLE) begin
            mem_stall = mem_req && !mem_ack;
        end else if (!mem_ack) begin
            if (mem_timer == TIMER_LAST) begin
                mem_expire = 1'b1;
            end else begin
                mem_stall = 1'b1;
            end
        end
    end

    // A flush wins over a start: the op never begins.
    always_comb begin
        ex_start_ok = ex_op_start && !ex_flush && (ex_cnt == '0);
        ex_multi    = ex_op_cycles >= EX_CNT_WIDTH'(2);
        ex_stall    = (ex_start_ok && ex_multi) || (ex_cnt > EX_CNT_WIDTH'(1));
        ex_done_raw = !ex_flush &&
                      (((ex_cnt == EX_CNT_WIDTH'(1)) && !mem_stall) ||
                       (ex_start_ok && !ex_multi));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_state <= MEM_IDLE;
            mem_timer <= '0;
        end else begin
            case (mem_state)
                MEM_IDLE: begin
                    if (mem_req && !mem_ack) begin
                        mem_state <= MEM_WAIT;
                        mem_timer <= TIMER_WIDTH'(1);
                    end
                end
                MEM_WAIT: begin
                    if (mem_ack || mem_expire) begin
                        mem_state <= MEM_IDLE;
                        mem_timer <= '0;
                    end else begin
                        mem_timer <= mem_timer + TIMER_WIDTH'(1);
                    end
                end
                default: begin
                    mem_state <= MEM_IDLE;
                    mem_timer <= '0;
                end
            endcase
        end
    end

    // MEM back-pressure freezes the EX countdown.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_cnt <= '0;
        end else if (ex_flush) begin
            ex_cnt <= '0;
        end else if (ex_start_ok && ex_multi) begin
            ex_cnt <= ex_op_cycles - EX_CNT_WIDTH'(1);
        end else if ((ex_cnt != '0) && !mem_stall) begin
            ex_cnt <= ex_cnt - EX_CNT_WIDTH'(1);
        end
    end

    always_comb begin
        stall       = '0;
        ex_op_done  = 1'b0;
        ex_busy     = 1'b0;
        mem_busy    = 1'b0;
        mem_timeout = 1'b0;
        if (rst) begin
            if (mem_stall) begin
                stall = STALL_WIDTH'(6'b011111);
            end else if (ex_stall) begin
                stall = STALL_WIDTH'(6'b001111);
            end else if (id_stall_req) begin
                stall = STALL_WIDTH'(6'b000111);
            end else if (if_stall_req) begin
                stall = STALL_WIDTH'(6'b000011);
            end
            ex_op_done  = ex_done_raw;
            ex_busy     = ex_cnt != '0;
            mem_busy    = mem_state == MEM_WAIT;
            mem_timeout = mem_expire;
        end
    end

endmodule
